// File: rtl/recovery_sequencer.sv
// ----------------------------------------------------------------------------
// recovery_sequencer
//
// Purpose:
//   Sequences branch-mispredict recovery once retire reports a mispredicted
//   head branch. It flushes the back end, stalls retire/dispatch/fetch, and
//   copies the architected map table into the speculative map table,
//   RESTORE_WIDTH entries per cycle. It then issues a handshaked redirect to
//   fetch. Every output is decoded from the registered FSM state.
//
// Ports:
//   clock, reset       clock (rising edge) and asynchronous active-high reset
//   recoverReq         1-cycle request from retire, sampled only while idle
//   recoverTarget      correct next PC, latched together with recoverReq
//   archReadAddrs      arch map read addresses, one per restore lane
//   archReadData       arch map read data (combinational response)
//   specWriteEn/Addrs/Data  spec map write port, one per restore lane
//   robFlushAll        clears ROB, RS, LSQ and in-flight FUs (FLUSH only)
//   freelistRestore    freelist rebuild from the arch map (FLUSH only)
//   retireStall, dispatchStall, fetchStall  held for the whole recovery
//   redirectValid/redirectPC/redirectReady  fetch redirect handshake
//   busy               high whenever a recovery is in progress
// ----------------------------------------------------------------------------
module recovery_sequencer #(
   parameter int N             = 4,
   parameter int ARCH_COUNT    = 32,
   parameter int RESTORE_WIDTH = 8,
   parameter int PHYS_REGS     = 64,
   localparam int REG_IDX      = (ARCH_COUNT > 1) ? $clog2(ARCH_COUNT) : 1,
   localparam int PHYS_TAG     = (PHYS_REGS > 1) ? $clog2(PHYS_REGS) : 1
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    recoverReq,
   input  logic [31:0]                             recoverTarget,
   output logic [RESTORE_WIDTH-1:0][REG_IDX-1:0]   archReadAddrs,
   input  logic [RESTORE_WIDTH-1:0][PHYS_TAG-1:0]  archReadData,
   output logic [RESTORE_WIDTH-1:0]                specWriteEn,
   output logic [RESTORE_WIDTH-1:0][REG_IDX-1:0]   specWriteAddrs,
   output logic [RESTORE_WIDTH-1:0][PHYS_TAG-1:0]  specWriteData,
   output logic                                    robFlushAll,
   output logic                                    freelistRestore,
   output logic                                    retireStall,
   output logic                                    dispatchStall,
   output logic                                    fetchStall,
   output logic                                    redirectValid,
   output logic [31:0]                             redirectPC,
   input  logic                                    redirectReady,
   output logic                                    busy
);

   // Number of restore chunks; the last one may be partial.
   localparam int R     = (ARCH_COUNT + RESTORE_WIDTH - 1) / RESTORE_WIDTH;
   localparam int CNT_W = $clog2(R) + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_RESTORE  = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        target_q, target_d;
   logic               last_chunk;
   logic               in_recovery;
   logic [N-1:0]       stall_lanes;

   assign last_chunk = (cnt_q == CNT_W'(R - 1));

   // State register: reset aborts any recovery immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
      end
   end

   // Next-state logic. A request arriving while busy is dropped: retire is
   // stalled during recovery, so such a request can only be a protocol error.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      case (state_q)
         ST_IDLE: begin
            if (recoverReq) begin
               target_d = recoverTarget;
               state_d  = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            cnt_d   = '0;
            state_d = ST_RESTORE;
         end
         ST_RESTORE: begin
            // Counter parks on the last chunk rather than wrapping.
            if (last_chunk) begin
               state_d = ST_REDIRECT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_REDIRECT: begin
            if (redirectReady) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_recovery = (state_q != ST_IDLE);
   // One stall bit per superscalar lane; every lane stalls together, so the
   // ports carry the collapsed value.
   assign stall_lanes = {N{in_recovery}};

   // Output decode from registered state.
   always_comb begin
      archReadAddrs   = '0;
      specWriteEn     = '0;
      specWriteAddrs  = '0;
      specWriteData   = '0;
      robFlushAll     = 1'b0;
      freelistRestore = 1'b0;
      redirectValid   = 1'b0;
      redirectPC      = '0;
      retireStall     = |stall_lanes;
      dispatchStall   = |stall_lanes;
      fetchStall      = |stall_lanes;
      busy            = in_recovery;

      case (state_q)
         ST_FLUSH: begin
            robFlushAll     = 1'b1;
            freelistRestore = 1'b1;
         end
         ST_RESTORE: begin
            // Lanes past ARCH_COUNT in a partial last chunk stay fully zero.
            for (int k = 0; k < RESTORE_WIDTH; k++) begin
               int idx;
               idx = int'(cnt_q) * RESTORE_WIDTH + k;
               if (idx < ARCH_COUNT) begin
                  archReadAddrs[k]  = REG_IDX'(idx);
                  specWriteAddrs[k] = REG_IDX'(idx);
                  specWriteEn[k]    = 1'b1;
                  specWriteData[k]  = archReadData[k];
               end
            end
         end
         ST_REDIRECT: begin
            redirectValid = 1'b1;
            redirectPC    = target_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_recovery_sequencer.sv
module tb_recovery_sequencer;

   localparam int RW  = 8;
   localparam int RI  = 5;
   localparam int TAG = 6;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;

   // DUT A: default ARCH_COUNT=32
   logic                      recoverReq;
   logic [31:0]               recoverTarget;
   logic [RW-1:0][RI-1:0]     archReadAddrs;
   logic [RW-1:0][TAG-1:0]    archReadData;
   logic [RW-1:0]             specWriteEn;
   logic [RW-1:0][RI-1:0]     specWriteAddrs;
   logic [RW-1:0][TAG-1:0]    specWriteData;
   logic robFlushAll, freelistRestore, retireStall, dispatchStall, fetchStall;
   logic redirectValid, redirectReady, busy;
   logic [31:0]               redirectPC;

   // DUT B: ARCH_COUNT=20
   logic                      recoverReq20;
   logic [31:0]               recoverTarget20;
   logic [RW-1:0][RI-1:0]     archReadAddrs20;
   logic [RW-1:0][TAG-1:0]    archReadData20;
   logic [RW-1:0]             specWriteEn20;
   logic [RW-1:0][RI-1:0]     specWriteAddrs20;
   logic [RW-1:0][TAG-1:0]    specWriteData20;
   logic robFlushAll20, freelistRestore20, retireStall20, dispatchStall20, fetchStall20;
   logic redirectValid20, redirectReady20, busy20;
   logic [31:0]               redirectPC20;

   recovery_sequencer #(.N(4), .ARCH_COUNT(32), .RESTORE_WIDTH(8), .PHYS_REGS(64)) dut (
      .clock(clock), .reset(reset), .recoverReq(recoverReq), .recoverTarget(recoverTarget),
      .archReadAddrs(archReadAddrs), .archReadData(archReadData),
      .specWriteEn(specWriteEn), .specWriteAddrs(specWriteAddrs), .specWriteData(specWriteData),
      .robFlushAll(robFlushAll), .freelistRestore(freelistRestore),
      .retireStall(retireStall), .dispatchStall(dispatchStall), .fetchStall(fetchStall),
      .redirectValid(redirectValid), .redirectPC(redirectPC), .redirectReady(redirectReady),
      .busy(busy));

   recovery_sequencer #(.N(4), .ARCH_COUNT(20), .RESTORE_WIDTH(8), .PHYS_REGS(64)) dut20 (
      .clock(clock), .reset(reset), .recoverReq(recoverReq20), .recoverTarget(recoverTarget20),
      .archReadAddrs(archReadAddrs20), .archReadData(archReadData20),
      .specWriteEn(specWriteEn20), .specWriteAddrs(specWriteAddrs20), .specWriteData(specWriteData20),
      .robFlushAll(robFlushAll20), .freelistRestore(freelistRestore20),
      .retireStall(retireStall20), .dispatchStall(dispatchStall20), .fetchStall(fetchStall20),
      .redirectValid(redirectValid20), .redirectPC(redirectPC20), .redirectReady(redirectReady20),
      .busy(busy20));

   // Arch map model answering the combinational read ports.
   logic [TAG-1:0] archMap [32];
   logic [TAG-1:0] specMap [32];
   logic           spec_clr = 1'b0;

   for (genvar k = 0; k < RW; k++) begin : g_rd
      assign archReadData[k]   = archMap[archReadAddrs[k]];
      assign archReadData20[k] = archMap[archReadAddrs20[k]];
   end

   // Spec map model written by DUT A.
   always @(posedge clock) begin
      if (spec_clr) begin
         for (int i = 0; i < 32; i++) specMap[i] <= '1;
      end else begin
         for (int k = 0; k < RW; k++)
            if (specWriteEn[k]) specMap[specWriteAddrs[k]] <= specWriteData[k];
      end
   end

   // Counts requests arriving while a recovery is in progress (illegal).
   int illegal_cnt = 0;
   always @(posedge clock)
      if (!reset && recoverReq && busy) illegal_cnt <= illegal_cnt + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        req;
      logic [31:0] tgt;
      logic        rdy;
      logic        busy;
      logic        flush;
      logic        rv;
      logic [31:0] pc;
      logic [7:0]  en;
      logic [4:0]  a0;
      int          lane;
      logic [4:0]  la;
      logic [5:0]  ld;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic req, logic [31:0] tgt, logic rdy, logic b, logic fl,
                               logic rv, logic [31:0] pc, logic [7:0] en, logic [4:0] a0, int lane);
      vec_t v;
      v.req = req; v.tgt = tgt; v.rdy = rdy; v.busy = b; v.flush = fl;
      v.rv = rv; v.pc = pc; v.en = en; v.a0 = a0; v.lane = lane;
      if (en[lane]) begin
         v.la = a0 + 5'(lane);
         v.ld = archMap[int'(a0) + lane];
      end else begin
         v.la = '0;
         v.ld = '0;
      end
      return v;
   endfunction

   task automatic run_seq(input logic [31:0] tgt, input bit glitch, input logic [31:0] gtgt,
                          output int cycles, output logic [31:0] pc_seen);
      @(negedge clock);
      recoverReq = 1'b1; recoverTarget = tgt; redirectReady = 1'b1;
      @(negedge clock);
      recoverReq = 1'b0; recoverTarget = 32'hFFFF_FFFF;
      cycles = 0; pc_seen = '0;
      for (int c = 0; c < 50; c++) begin
         if (!busy) break;
         cycles++;
         if (redirectValid) pc_seen = redirectPC;
         if (glitch && c == 2) begin
            recoverReq = 1'b1; recoverTarget = gtgt;
         end else begin
            recoverReq = 1'b0;
         end
         @(negedge clock);
      end
      recoverReq = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          mism;
      int          ill0;
      logic [31:0] pcs;
      logic [7:0]  e20_en [6];
      logic        e20_b  [6];
      logic        e20_rv [6];
      logic [4:0]  e20_a0 [6];

      for (int i = 0; i < 32; i++) archMap[i] = TAG'((i * 5 + 1) % 64);
      archMap[0]  = 6'd0;
      archMap[5]  = 6'd37;
      archMap[31] = 6'd12;

      reset = 1'b1;
      recoverReq = 1'b0; recoverTarget = '0; redirectReady = 1'b0;
      recoverReq20 = 1'b0; recoverTarget20 = '0; redirectReady20 = 1'b1;

      // Reset state
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_outs", 64'({robFlushAll, freelistRestore, retireStall, dispatchStall,
                              fetchStall, redirectValid}), 64'd0);
      check("rst_pc", 64'(redirectPC), 64'd0);
      check("rst_en", 64'(specWriteEn), 64'd0);
      check("rst_busy20", 64'(busy20), 64'd0);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;

      // Basic sequence with ready=1
      tv.push_back(mk(1, 32'h0000_1040, 1, 1, 1, 0, 0,            8'h00, 0,  0));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, 0, 0,            8'hFF, 0,  5));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, 0, 0,            8'hFF, 8,  0));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, 0, 0,            8'hFF, 16, 3));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, 0, 0,            8'hFF, 24, 7));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, 1, 32'h1040,     8'h00, 0,  0));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0,            8'h00, 0,  0));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,            8'h00, 0,  0));
      // Redirect back-pressure: ready low for 4 REDIRECT cycles
      tv.push_back(mk(1, 32'h2000_0ABC, 0, 1, 1, 0, 0,            8'h00, 0,  0));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0,            8'hFF, 0,  1));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0,            8'hFF, 8,  2));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0,            8'hFF, 16, 6));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0,            8'hFF, 24, 7));
      for (int i = 0; i < 5; i++)
         tv.push_back(mk(0, 32'hFFFF_FFFF, 0, 1, 0, 1, 32'h2000_0ABC, 8'h00, 0, 0));
      tv.push_back(mk(0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0,            8'h00, 0,  0));

      foreach (tv[i]) begin
         @(negedge clock);
         recoverReq = tv[i].req; recoverTarget = tv[i].tgt; redirectReady = tv[i].rdy;
         @(posedge clock);
         #1;
         check($sformatf("v%0d_busy", i), 64'(busy), 64'(tv[i].busy));
         check($sformatf("v%0d_stalls", i), 64'({retireStall, dispatchStall, fetchStall}),
               64'({3{tv[i].busy}}));
         check($sformatf("v%0d_flush", i), 64'({robFlushAll, freelistRestore}),
               64'({2{tv[i].flush}}));
         check($sformatf("v%0d_rv", i), 64'(redirectValid), 64'(tv[i].rv));
         check($sformatf("v%0d_pc", i), 64'(redirectPC), 64'(tv[i].pc));
         check($sformatf("v%0d_en", i), 64'(specWriteEn), 64'(tv[i].en));
         check($sformatf("v%0d_ra0", i), 64'(archReadAddrs[0]), 64'(tv[i].a0));
         check($sformatf("v%0d_wa", i), 64'(specWriteAddrs[tv[i].lane]), 64'(tv[i].la));
         check($sformatf("v%0d_wd", i), 64'(specWriteData[tv[i].lane]), 64'(tv[i].ld));
      end
      recoverReq = 1'b0;

      // Asynchronous reset in the second RESTORE cycle
      @(negedge clock);
      recoverReq = 1'b1; recoverTarget = 32'h0000_3000; redirectReady = 1'b1;
      @(negedge clock);
      recoverReq = 1'b0;
      @(posedge clock); @(posedge clock);
      #2;
      check("mid_restore_en", 64'(specWriteEn), 64'hFF);
      reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_stalls", 64'({retireStall, dispatchStall, fetchStall}), 64'd0);
      check("arst_en", 64'(specWriteEn), 64'd0);
      check("arst_addrs", 64'(archReadAddrs), 64'd0);
      check("arst_waddrs", 64'(specWriteAddrs), 64'd0);
      check("arst_wdata", 64'(specWriteData), 64'd0);
      check("arst_rv", 64'({redirectValid, robFlushAll, freelistRestore}), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      spec_clr = 1'b1;
      @(negedge clock);
      spec_clr = 1'b0;
      run_seq(32'h0000_4444, 1'b0, 32'h0, cyc, pcs);
      check("post_rst_len", 64'(cyc), 64'd6);
      check("post_rst_pc", 64'(pcs), 64'h4444);
      mism = 0;
      for (int i = 0; i < 32; i++) if (specMap[i] !== archMap[i]) mism++;
      check("specmap_restored", 64'(mism), 64'd0);

      // Illegal second request during RESTORE
      ill0 = illegal_cnt;
      run_seq(32'h0000_5550, 1'b1, 32'h0000_9990, cyc, pcs);
      check("glitch_len", 64'(cyc), 64'd6);
      check("glitch_pc", 64'(pcs), 64'h5550);
      check("glitch_flagged", 64'(illegal_cnt - ill0), 64'd1);
      check("glitch_idle", 64'(busy), 64'd0);

      // Partial last chunk with ARCH_COUNT=20
      e20_en = '{8'h00, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00};
      e20_b  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      e20_rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      e20_a0 = '{5'd0, 5'd0, 5'd8, 5'd16, 5'd0, 5'd0};
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         recoverReq20 = (c == 0); recoverTarget20 = (c == 0) ? 32'h0000_7700 : 32'hFFFF_FFFF;
         @(posedge clock);
         #1;
         check($sformatf("a20_c%0d_busy", c), 64'(busy20), 64'(e20_b[c]));
         check($sformatf("a20_c%0d_en", c), 64'(specWriteEn20), 64'(e20_en[c]));
         check($sformatf("a20_c%0d_a0", c), 64'(specWriteAddrs20[0]), 64'(e20_a0[c]));
         check($sformatf("a20_c%0d_rv", c), 64'(redirectValid20), 64'(e20_rv[c]));
         if (c == 3) begin
            check("a20_lane3_addr", 64'(archReadAddrs20[3]), 64'd19);
            check("a20_lane3_data", 64'(specWriteData20[3]), 64'(archMap[19]));
            check("a20_lane4_addr", 64'(specWriteAddrs20[4]), 64'd0);
            check("a20_lane4_data", 64'(specWriteData20[4]), 64'd0);
         end
         if (c == 4) check("a20_pc", 64'(redirectPC20), 64'h7700);
      end
      recoverReq20 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
